// File: rtl/riscv_imm_pkg.sv
// -----------------------------------------------------------------------------
// riscv_imm_pkg
// Shared definitions for the pipelined immediate generator.
//   IMM_*        : 3-bit immediate format select codes driven on imm_src
//   buf_state_e  : occupancy of the two-entry output skid buffer
// -----------------------------------------------------------------------------
package riscv_imm_pkg;

   localparam logic [2:0] IMM_I   = 3'b000;
   localparam logic [2:0] IMM_S   = 3'b001;
   localparam logic [2:0] IMM_U   = 3'b010;
   localparam logic [2:0] IMM_B   = 3'b011;
   localparam logic [2:0] IMM_J   = 3'b100;
   localparam logic [2:0] IMM_Z   = 3'b101;
   localparam logic [2:0] IMM_SH  = 3'b110;
   localparam logic [2:0] IMM_BAD = 3'b111;

   // EMPTY: nothing buffered, ONE: main register valid,
   // FULL: main holds the oldest entry and skid holds the next one.
   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      FULL
   } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
// Combinational immediate extractor for RV32/RV64 instruction formats.
//   i_instr  : raw 32-bit instruction word
//   i_immSrc : immediate format select (IMM_* codes)
//   o_imm    : immediate extended to XLEN bits
//   o_err    : format select is illegal for this XLEN
// -----------------------------------------------------------------------------
module imm_decode
   import riscv_imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_instr,
   input  logic [2:0]      i_immSrc,
   output logic [XLEN-1:0] o_imm,
   output logic            o_err
);

   // The opcode field never contributes to an immediate.
   logic w_unusedOpcode;
   assign w_unusedOpcode = ^i_instr[6:0];

   // Signed size casts perform the replication of instr[31] up to XLEN, which
   // also gives the RV64 sign extension of bit 31 for U-type for free.
   // The default path covers IMM_BAD so every select yields a defined value.
   always_comb begin
      o_imm = '0;
      o_err = 1'b0;
      case (i_immSrc)
         IMM_I: o_imm = XLEN'($signed(i_instr[31:20]));
         IMM_S: o_imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
         IMM_B: o_imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                       i_instr[11:8], 1'b0}));
         IMM_U: o_imm = XLEN'($signed({i_instr[31:12], 12'b0}));
         IMM_J: o_imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                       i_instr[30:21], 1'b0}));
         IMM_Z: o_imm = XLEN'(i_instr[19:15]);
         IMM_SH: begin
            if (XLEN == 64) begin
               o_imm = XLEN'(i_instr[25:20]);
            end else begin
               o_imm = XLEN'(i_instr[24:20]);
               o_err = i_instr[25];
            end
         end
         default: begin
            o_imm = '0;
            o_err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Immediate decoder registered behind a two-entry valid/ready skid buffer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous discard of all buffered entries
//   in_valid / in_ready : upstream handshake
//   instr, imm_src      : instruction word and immediate format select
//   in_tag / out_tag    : sideband carried alongside each immediate
//   out_valid/out_ready : downstream handshake
//   imm_ext, imm_err    : extended immediate and illegal-format flag
// -----------------------------------------------------------------------------
module imm_gen_pipe
   import riscv_imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [2:0]       imm_src,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_ext,
   output logic [TAG_W-1:0] out_tag,
   output logic             imm_err
);

   buf_state_e       r_state;
   buf_state_e       w_nextState;
   logic             w_push;
   logic             w_pop;
   logic             w_loadMainIn;
   logic             w_loadMainSkid;
   logic             w_loadSkid;
   logic [XLEN-1:0]  w_decImm;
   logic             w_decErr;
   logic [XLEN-1:0]  r_mainImm;
   logic [TAG_W-1:0] r_mainTag;
   logic             r_mainErr;
   logic [XLEN-1:0]  r_skidImm;
   logic [TAG_W-1:0] r_skidTag;
   logic             r_skidErr;

   imm_decode #(
      .XLEN(XLEN)
   ) u_decode (
      .i_instr (instr),
      .i_immSrc(imm_src),
      .o_imm   (w_decImm),
      .o_err   (w_decErr)
   );

   // Both handshake outputs depend only on the state register, so out_ready
   // never reaches in_ready combinationally and the stall chain stays cut.
   assign in_ready  = (r_state != FULL);
   assign out_valid = (r_state != EMPTY);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   // State register; reset drops every buffered entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and load selection. Flush overrides any concurrent push or
   // pop. A simultaneous push and pop in ONE replaces main directly, so the
   // skid register is only ever used while downstream is stalled.
   always_comb begin
      w_nextState    = r_state;
      w_loadMainIn   = 1'b0;
      w_loadMainSkid = 1'b0;
      w_loadSkid     = 1'b0;
      if (flush) begin
         w_nextState = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_push) begin
                  w_nextState  = ONE;
                  w_loadMainIn = 1'b1;
               end
            end
            ONE: begin
               if (w_push && w_pop) begin
                  w_loadMainIn = 1'b1;
               end else if (w_push) begin
                  w_nextState = FULL;
                  w_loadSkid  = 1'b1;
               end else if (w_pop) begin
                  w_nextState = EMPTY;
               end
            end
            FULL: begin
               if (w_pop) begin
                  w_nextState    = ONE;
                  w_loadMainSkid = 1'b1;
               end
            end
            default: w_nextState = EMPTY;
         endcase
      end
   end

   // Data registers only change on a load, which keeps the presented entry
   // stable while downstream stalls. Stale contents after a flush are harmless
   // because out_valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mainImm <= '0;
         r_mainTag <= '0;
         r_mainErr <= 1'b0;
         r_skidImm <= '0;
         r_skidTag <= '0;
         r_skidErr <= 1'b0;
      end else begin
         if (w_loadMainIn) begin
            r_mainImm <= w_decImm;
            r_mainTag <= in_tag;
            r_mainErr <= w_decErr;
         end else if (w_loadMainSkid) begin
            r_mainImm <= r_skidImm;
            r_mainTag <= r_skidTag;
            r_mainErr <= r_skidErr;
         end
         if (w_loadSkid) begin
            r_skidImm <= w_decImm;
            r_skidTag <= in_tag;
            r_skidErr <= w_decErr;
         end
      end
   end

   assign imm_ext = r_mainImm;
   assign out_tag = r_mainTag;
   assign imm_err = r_mainErr;

endmodule
